// File: rtl/keccak_share_loader_ctrl.sv
// keccak_share_loader_ctrl
//   Per-share controller around the masked theta / state-register stage.
//   It collects the input state over a DW-bit valid/ready load bus and then
//   sequences CoreReset, EnableLambda, Lastround and RoundIdx through ROUNDS
//   rounds of CPR cycles each. Finally it drains the state register back out
//   over a DW-bit valid/ready unload bus. Every share instance runs in lockstep.
//
//   Build option: when KECCAK_LOADER_ZEROIZE_EN is defined, the load buffer is
//   cleared once START has consumed it. The unload buffer is cleared once its
//   last beat has gone out, and also on Abort. This build option does not
//   change the timing of any other output.
module keccak_share_loader_ctrl #(
    parameter int W      = 8,
    parameter int b      = 25 * W,
    parameter int DW     = 8,
    parameter int ROUNDS = 18,
    parameter int CPR    = 1,
    localparam int NBEATS = b / DW,
    localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1,
    localparam int RW     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1,
    localparam int CW     = (CPR > 1) ? $clog2(CPR) : 1
) (
    input  logic          Clock,
    input  logic          ResetN,
    input  logic          Abort,
    input  logic [DW-1:0] DataIn,
    input  logic          DataValid,
    output logic          DataReady,
    output logic [b-1:0]  InputShares,
    output logic          CoreReset,
    output logic          Lastround,
    output logic          EnableLambda,
    output logic [RW-1:0] RoundIdx,
    input  logic [b-1:0]  StateOut,
    output logic [DW-1:0] OutData,
    output logic          OutValid,
    input  logic          OutReady,
    output logic          Busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        RUN,
        UNLOAD
    } stateType;

    stateType      state;
    stateType      stateNext;

    logic [BW-1:0] beatCnt;
    logic [RW-1:0] roundCnt;
    logic [CW-1:0] cycleCnt;
    logic [b-1:0]  loadBuf;
    logic [b-1:0]  unloadBuf;
    // Set once StateOut has been copied into unloadBuf during the current unload.
    logic          captured;

    logic          lastBeat;
    logic          roundEnd;
    logic          finalRound;
    logic          loadFire;
    logic          unloadFire;

    assign lastBeat    = (beatCnt == BW'(NBEATS - 1));
    assign roundEnd    = (cycleCnt == CW'(CPR - 1));
    assign finalRound  = (roundCnt == RW'(ROUNDS - 1));
    assign loadFire    = DataValid && DataReady;
    assign unloadFire  = OutValid && OutReady;
    assign InputShares = loadBuf;

    // State register.
    always_ff @(posedge Clock or negedge ResetN) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop
        // samples values from before the edge and no ordering race between
        // always blocks can occur.
        if (!ResetN) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state decode: Abort overrides every transition, including a handshake in the same cycle.
    always_comb begin
        // NOTE: a default assignment at the top of a combinational block means
        // every path assigns the variable, so no latch can be inferred.
        stateNext = state;
        if (Abort) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE, LOAD: if (loadFire) stateNext = lastBeat ? START : LOAD;
                START:      stateNext = RUN;
                RUN:        if (roundEnd && finalRound) stateNext = UNLOAD;
                UNLOAD:     if (unloadFire && lastBeat) stateNext = IDLE;
                default:    stateNext = IDLE;
            endcase
        end
    end

    // Output decode: the control strobes are masked by Abort so that an aborted cycle never captures.
    always_comb begin
        DataReady    = 1'b0;
        CoreReset    = 1'b0;
        EnableLambda = 1'b0;
        Lastround    = 1'b0;
        RoundIdx     = '0;
        OutValid     = 1'b0;
        Busy         = (state != IDLE);
        case (state)
            IDLE, LOAD: DataReady = !Abort;
            START: begin
                CoreReset    = !Abort;
                EnableLambda = !Abort;
            end
            RUN: begin
                RoundIdx     = roundCnt;
                EnableLambda = !Abort && roundEnd;
                Lastround    = !Abort && roundEnd && finalRound;
            end
            UNLOAD:  OutValid = !Abort;
            default: ;
        endcase
        // On the first UNLOAD cycle the buffer is still being filled, so beat 0
        // comes straight from the state register, which is already stable.
        if (state == UNLOAD && !captured) begin
            OutData = StateOut[int'(beatCnt) * DW +: DW];
        end else begin
            OutData = unloadBuf[int'(beatCnt) * DW +: DW];
        end
    end

    // Counters and buffers: beat assembly, round and cycle sequencing, and unload capture and drain.
    always_ff @(posedge Clock or negedge ResetN) begin
        // NOTE: both state buffers are reset because they drive outputs
        // directly (InputShares, OutData), and those outputs must read as zero
        // after reset.
        if (!ResetN) begin
            beatCnt   <= '0;
            roundCnt  <= '0;
            cycleCnt  <= '0;
            loadBuf   <= '0;
            unloadBuf <= '0;
            captured  <= 1'b0;
        end else if (Abort) begin
            beatCnt  <= '0;
            roundCnt <= '0;
            cycleCnt <= '0;
            captured <= 1'b0;
`ifdef KECCAK_LOADER_ZEROIZE_EN
            unloadBuf <= '0;
`endif
        end else begin
            case (state)
                IDLE, LOAD: begin
                    if (loadFire) begin
                        loadBuf[int'(beatCnt) * DW +: DW] <= DataIn;
                        beatCnt <= lastBeat ? '0 : beatCnt + 1'b1;
                    end
                end
                START: begin
                    roundCnt <= '0;
                    cycleCnt <= '0;
`ifdef KECCAK_LOADER_ZEROIZE_EN
                    loadBuf <= '0;
`endif
                end
                RUN: begin
                    if (roundEnd) begin
                        cycleCnt <= '0;
                        roundCnt <= finalRound ? '0 : roundCnt + 1'b1;
                    end else begin
                        cycleCnt <= cycleCnt + 1'b1;
                    end
                end
                UNLOAD: begin
                    if (!captured) begin
                        unloadBuf <= StateOut;
                        captured  <= 1'b1;
                    end
                    if (unloadFire) begin
                        beatCnt <= lastBeat ? '0 : beatCnt + 1'b1;
                        if (lastBeat) begin
                            captured <= 1'b0;
`ifdef KECCAK_LOADER_ZEROIZE_EN
                            unloadBuf <= '0;
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_share_loader_ctrl.sv
// tb_keccak_share_loader_ctrl
//   Directed bench for keccak_share_loader_ctrl. A small behavioural state
//   register stands in for the theta stage: CoreReset loads InputShares, and
//   each later capture rotates the state left by one byte and XORs in RoundIdx.
//   When the bench is built with KECCAK_LOADER_ZEROIZE_EN, it expects the
//   buffers to be cleared.
module tb_keccak_share_loader_ctrl;

    localparam int B      = 200;
    localparam int DW     = 8;
    localparam int ROUNDS = 18;
    localparam int NB     = B / DW;

    logic          Clock = 1'b0;
    logic          ResetN = 1'b0;
    logic          Abort = 1'b0;
    logic [DW-1:0] DataIn = '0;
    logic          DataValid = 1'b0;
    logic          DataReady;
    logic [B-1:0]  InputShares;
    logic          CoreReset;
    logic          Lastround;
    logic          EnableLambda;
    logic [4:0]    RoundIdx;
    logic [B-1:0]  StateOut;
    logic [DW-1:0] OutData;
    logic          OutValid;
    logic          OutReady = 1'b0;
    logic          Busy;

    // Second instance with a three-cycle round.
    logic          c3Abort = 1'b0;
    logic [DW-1:0] c3DataIn = '0;
    logic          c3DataValid = 1'b0;
    logic          c3DataReady;
    logic [B-1:0]  c3InputShares;
    logic          c3CoreReset;
    logic          c3Lastround;
    logic          c3EnableLambda;
    logic [4:0]    c3RoundIdx;
    logic [B-1:0]  c3StateOut = '0;
    logic [DW-1:0] c3OutData;
    logic          c3OutValid;
    logic          c3OutReady = 1'b0;
    logic          c3Busy;

    int nCompared = 0;
    int nMismatched = 0;

    always #5 Clock = ~Clock;

    keccak_share_loader_ctrl #(.W(8), .b(B), .DW(DW), .ROUNDS(ROUNDS), .CPR(1)) dut (
        .Clock(Clock), .ResetN(ResetN), .Abort(Abort), .DataIn(DataIn),
        .DataValid(DataValid), .DataReady(DataReady), .InputShares(InputShares),
        .CoreReset(CoreReset), .Lastround(Lastround), .EnableLambda(EnableLambda),
        .RoundIdx(RoundIdx), .StateOut(StateOut), .OutData(OutData),
        .OutValid(OutValid), .OutReady(OutReady), .Busy(Busy)
    );

    keccak_share_loader_ctrl #(.W(8), .b(B), .DW(DW), .ROUNDS(ROUNDS), .CPR(3)) dut3 (
        .Clock(Clock), .ResetN(ResetN), .Abort(c3Abort), .DataIn(c3DataIn),
        .DataValid(c3DataValid), .DataReady(c3DataReady), .InputShares(c3InputShares),
        .CoreReset(c3CoreReset), .Lastround(c3Lastround), .EnableLambda(c3EnableLambda),
        .RoundIdx(c3RoundIdx), .StateOut(c3StateOut), .OutData(c3OutData),
        .OutValid(c3OutValid), .OutReady(c3OutReady), .Busy(c3Busy)
    );

    // Stand-in theta/state register. It keeps changing after the first unload
    // cycle, so the design's buffer must capture on that cycle.
    logic [B-1:0] stateReg;
    assign StateOut = stateReg;
    always @(posedge Clock or negedge ResetN) begin
        if (!ResetN) stateReg <= '0;
        else if (EnableLambda)
            stateReg <= CoreReset ? InputShares
                                  : ({stateReg[B-9:0], stateReg[B-1:B-8]} ^ B'(RoundIdx));
        else if (OutValid) stateReg <= ~stateReg;
    end

    task automatic check(input string name, input logic [B-1:0] act, input logic [B-1:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [B-1:0] makeLoad(input logic [7:0] base);
        logic [B-1:0] v;
        v = '0;
        for (int k = 0; k < NB; k++) v[k*8 +: 8] = base + 8'(k);
        return v;
    endfunction

    function automatic logic [B-1:0] expFinal(input logic [B-1:0] ld);
        logic [B-1:0] s;
        s = ld;
        for (int r = 0; r < ROUNDS; r++) s = {s[B-9:0], s[B-1:B-8]} ^ B'(r);
        return s;
    endfunction

    typedef struct {
        logic dataValid;
        logic outReady;
        logic eCore;
        logic eEn;
        logic eLast;
        logic eValid;
        logic eBusy;
        logic eReady;
        int   eIdx;
    } vecT;

    vecT vecs[19];

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    // Entered at posedge+1 in IDLE. Returns at posedge+1 of the START cycle.
    task automatic loadBeats(input logic [7:0] base);
        for (int k = 0; k < NB; k++) begin
            DataValid = 1'b1;
            DataIn    = base + 8'(k);
            @(negedge Clock);
            check($sformatf("load_ready_b%0d", k), DataReady, 1'b1);
            cyc();
        end
        DataValid = 1'b0;
    endtask

    // Covers START and the 18 RUN cycles, one table entry per cycle.
    task automatic runTable(input logic [B-1:0] ld);
        for (int i = 0; i < 19; i++) begin
            DataValid = vecs[i].dataValid;
            DataIn    = 8'hEE;
            OutReady  = vecs[i].outReady;
            @(negedge Clock);
            check($sformatf("v%0d_ctrl", i),
                  {CoreReset, EnableLambda, Lastround, OutValid, Busy, DataReady},
                  {vecs[i].eCore, vecs[i].eEn, vecs[i].eLast, vecs[i].eValid,
                   vecs[i].eBusy, vecs[i].eReady});
            check($sformatf("v%0d_idx", i), RoundIdx, vecs[i].eIdx[4:0]);
            if (i == 0) check("shares_at_start", InputShares, ld);
`ifdef KECCAK_LOADER_ZEROIZE_EN
            if (i == 1) check("shares_zeroized", InputShares, '0);
`else
            if (i == 1) check("shares_held", InputShares, ld);
`endif
            cyc();
        end
        DataValid = 1'b0;
        OutReady  = 1'b0;
    endtask

    // Handshakes all beats with OutReady following the pattern 1,0,0,1,0,0,...
    task automatic unloadAll(input string tag, input logic [B-1:0] expS);
        int k;
        int p;
        k = 0;
        p = 0;
        while (k < NB && p < 300) begin
            OutReady  = (p % 3 == 0);
            DataValid = 1'b1;
            @(negedge Clock);
            if (!OutValid || OutData !== expS[k*8 +: 8] || p == 0) begin
                check($sformatf("%s_valid_p%0d", tag, p), OutValid, 1'b1);
                check($sformatf("%s_data_p%0d_b%0d", tag, p, k), OutData, expS[k*8 +: 8]);
            end
            cyc();
            if (OutReady) k++;
            p++;
        end
        OutReady  = 1'b0;
        DataValid = 1'b0;
        check({tag, "_beats_taken"}, k, NB);
        check({tag, "_all_beats_ok"}, p, 3 * NB - 2);
        @(negedge Clock);
        check({tag, "_idle_after"}, {Busy, OutValid, DataReady}, 3'b001);
`ifdef KECCAK_LOADER_ZEROIZE_EN
        check({tag, "_unload_zeroized"}, OutData, 8'h00);
`else
        check({tag, "_unload_retained"}, OutData, expS[7:0]);
`endif
        cyc();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [B-1:0] ld;
        bit found;
        int pulses;
        int pulseErr;
        int lrErr;
        int firstValid;

        vecs[0] = '{dataValid: 1'b1, outReady: 1'b0, eCore: 1'b1, eEn: 1'b1, eLast: 1'b0,
                    eValid: 1'b0, eBusy: 1'b1, eReady: 1'b0, eIdx: 0};
        for (int r = 0; r < ROUNDS; r++)
            vecs[r+1] = '{dataValid: r[0], outReady: 1'b1, eCore: 1'b0, eEn: 1'b1,
                          eLast: (r == ROUNDS - 1), eValid: 1'b0, eBusy: 1'b1,
                          eReady: 1'b0, eIdx: r};

        // Reset state.
        repeat (2) @(posedge Clock);
        #1;
        ResetN = 1'b1;
        @(negedge Clock);
        check("reset_ctrl", {Busy, DataReady, OutValid, EnableLambda, CoreReset, Lastround},
              6'b010000);
        check("reset_shares", InputShares, '0);
        check("reset_outdata", OutData, 8'h00);
        check("reset_idx", RoundIdx, 5'd0);
        cyc();

        // Continuous load, round sequencing, unload under stalls.
        ld = makeLoad(8'h00);
        loadBeats(8'h00);
        runTable(ld);
        unloadAll("run0", expFinal(ld));

        // Abort during round 5, together with DataValid.
        ld = makeLoad(8'h40);
        loadBeats(8'h40);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge Clock);
            if (Busy && RoundIdx == 5'd5) found = 1'b1;
            else cyc();
        end
        check("abort_reached_round5", found, 1'b1);
        Abort     = 1'b1;
        DataValid = 1'b1;
        DataIn    = 8'hAA;
        #1;
        check("abort_cycle_no_lambda", EnableLambda, 1'b0);
        check("abort_cycle_no_ready", DataReady, 1'b0);
        cyc();
        Abort     = 1'b0;
        DataValid = 1'b0;
        @(negedge Clock);
        check("abort_idle", {Busy, DataReady, OutValid, CoreReset}, 4'b0100);
        check("abort_idx_zero", RoundIdx, 5'd0);
        pulses = 0;
        repeat (6) begin
            cyc();
            if (EnableLambda) pulses++;
        end
        check("abort_no_more_pulses", pulses, 0);
`ifdef KECCAK_LOADER_ZEROIZE_EN
        check("abort_shares", InputShares, '0);
`else
        check("abort_shares", InputShares, ld);
`endif

        // A full operation runs normally after the abort.
        ld = makeLoad(8'h80);
        loadBeats(8'h80);
        runTable(ld);
        unloadAll("run1", expFinal(ld));

        // Asynchronous reset in the middle of RUN.
        loadBeats(8'h10);
        repeat (4) cyc();
        #2;
        ResetN = 1'b0;
        #1;
        check("midrun_reset_ctrl", {Busy, EnableLambda, DataReady, OutValid}, 4'b0010);
        check("midrun_reset_shares", InputShares, '0);
        @(negedge Clock);
        ResetN = 1'b1;
        cyc();

        // CPR = 3: one pulse every third cycle, first OutValid at +56.
        for (int k = 0; k < NB; k++) begin
            c3DataValid = 1'b1;
            c3DataIn    = 8'(k);
            cyc();
        end
        c3DataValid = 1'b0;
        pulses = 0;
        pulseErr = 0;
        lrErr = 0;
        firstValid = -1;
        for (int i = 1; i <= 70 && firstValid < 0; i++) begin
            @(negedge Clock);
            if (c3EnableLambda !== ((i == 1) || (i >= 4 && i <= 55 && (i - 1) % 3 == 0)))
                pulseErr++;
            if (c3Lastround !== (i == 55)) lrErr++;
            if (c3EnableLambda && i > 1) pulses++;
            if (c3OutValid) firstValid = i;
            else cyc();
        end
        check("cpr3_pulse_pattern_errors", pulseErr, 0);
        check("cpr3_pulse_count", pulses, ROUNDS);
        check("cpr3_lastround_errors", lrErr, 0);
        check("cpr3_first_outvalid", firstValid, 56);
        c3Abort    = 1'b1;
        c3OutReady = 1'b1;
        cyc();
        c3Abort    = 1'b0;
        c3OutReady = 1'b0;
        @(negedge Clock);
        check("cpr3_abort_unload", {c3Busy, c3OutValid, c3DataReady}, 3'b001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
